// File: rtl/lasd_pkg.sv
// ---------------------------------------------------------------------------
// lasd_pkg -- shared definitions for the register-dump serial transmitter.
//
// Contents:
//   state_t         sequencing states of reg_dump_tx
//   HEADER_DEFAULT  frame sync byte used when no HEADER override is given
//   FRAME_LEN       bytes per frame (header + 8 registers + checksum)
//   LAST_INDEX      byte index of the checksum, the final byte of a frame
//   LAST_DATA_POS   bit position of the last data bit inside one character
//   STOP_POS        bit position of the stop bit inside one character
//   is_reg_index()  true for byte indices that carry a register value
// ---------------------------------------------------------------------------
package lasd_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        START,
        DATA,
        STOP
    } state_t;

    localparam logic [7:0] HEADER_DEFAULT = 8'hA5;
    localparam int         FRAME_LEN      = 10;
    localparam logic [3:0] LAST_INDEX     = 4'(FRAME_LEN - 1);

    // Character layout: position 0 is the start bit, 1..8 the data bits
    // (LSB first) and 9 the stop bit.
    localparam logic [3:0] LAST_DATA_POS  = 4'd8;
    localparam logic [3:0] STOP_POS       = 4'd9;

    // Byte indices 1..8 carry register file contents (reg0..reg7).
    function automatic logic is_reg_index(input logic [3:0] idx);
        return (idx >= 4'd1) && (idx <= 4'd8);
    endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// ---------------------------------------------------------------------------
// uart_tx_byte -- transmits one 8N1 character (start, 8 data LSB first, stop)
// with a programmable bit period.  Sequencing of multi-byte messages is left
// to the instantiating block.
//
// Ports:
//   clk      in   sole clock, rising edge
//   rst      in   synchronous active-high reset
//   load     in   accept data and begin a character (ignored while busy)
//   data     in   byte to send
//   tx       out  registered serial line, idle high
//   ready    out  high when no character is in flight
//   bit_end  out  high in the final clock of the current bit period
//   bit_pos  out  current bit position (0 start, 1..8 data, 9 stop)
// ---------------------------------------------------------------------------
module uart_tx_byte
    import lasd_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] data,
    output logic       tx,
    output logic       ready,
    output logic       bit_end,
    output logic [3:0] bit_pos
);

    localparam int             CW         = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0]  LAST_COUNT = CW'(CLKS_PER_BIT - 1);

    logic          active;
    logic [CW-1:0] count;
    logic [7:0]    shifter;
    logic [3:0]    pos;

    // A bit period ends when the counter reaches CLKS_PER_BIT-1; the line
    // value for the next bit is registered on that same edge so tx never
    // glitches between periods.
    assign bit_end = active && (count == LAST_COUNT);
    assign ready   = !active;
    assign bit_pos = pos;

    // Character engine.  Loading drives the start bit immediately on the
    // following edge, so a character takes exactly 10 bit periods after the
    // load cycle.  The shifter is consumed from bit 0 upward, giving LSB-first
    // order; after the last data bit the line returns high for the stop bit
    // and stays high once the character is finished.
    always_ff @(posedge clk) begin
        if (rst) begin
            active  <= 1'b0;
            count   <= '0;
            pos     <= 4'd0;
            shifter <= 8'h00;
            tx      <= 1'b1;
        end else if (load && !active) begin
            active  <= 1'b1;
            count   <= '0;
            pos     <= 4'd0;
            shifter <= data;
            tx      <= 1'b0;
        end else if (active) begin
            if (bit_end) begin
                count <= '0;
                if (pos == STOP_POS) begin
                    active <= 1'b0;
                    pos    <= 4'd0;
                    tx     <= 1'b1;
                end else begin
                    pos <= pos + 4'd1;
                    if (pos < LAST_DATA_POS) begin
                        tx      <= shifter[0];
                        shifter <= {1'b0, shifter[7:1]};
                    end else begin
                        tx <= 1'b1;
                    end
                end
            end else begin
                count <= count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/reg_dump_tx.sv
// ---------------------------------------------------------------------------
// reg_dump_tx -- on request, reads an 8-entry register file and sends it as a
// 10-byte serial frame: HEADER, reg0..reg7, XOR checksum of the 8 registers.
//
// Ports:
//   clk    in   sole clock, rising edge
//   rst    in   synchronous active-high reset
//   start  in   request one frame (only honoured while idle)
//   ra     out  registered register-file read address
//   rd     in   register-file read data, combinational from ra
//   tx     out  registered 8N1 serial line, idle high
//   busy   out  high for the whole frame
//   done   out  one-cycle pulse in the first idle cycle after a frame
// ---------------------------------------------------------------------------
module reg_dump_tx
    import lasd_pkg::*;
#(
    parameter int         CLKS_PER_BIT = 434,
    parameter logic [7:0] HEADER       = HEADER_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic [2:0] ra,
    input  logic [7:0] rd,
    output logic       tx,
    output logic       busy,
    output logic       done
);

    state_t     state;
    state_t     next_state;
    logic [3:0] index;
    logic [7:0] checksum;
    logic       load;
    logic [7:0] load_byte;
    logic       tx_ready;
    logic       bit_end;
    logic [3:0] bit_pos;
    logic       frame_end;

    // The character engine owns bit timing; this block only decides which
    // byte goes next and when the frame is over.
    uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_byte (
        .clk    (clk),
        .rst    (rst),
        .load   (load),
        .data   (load_byte),
        .tx     (tx),
        .ready  (tx_ready),
        .bit_end(bit_end),
        .bit_pos(bit_pos)
    );

    assign frame_end = (state == STOP) && bit_end && (index == LAST_INDEX);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic.  START/DATA/STOP mirror the character engine's bit
    // position so the sequencer knows when a byte has fully left the line;
    // after the stop bit either the next byte is fetched or the frame ends.
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:  if (start) next_state = FETCH;
            FETCH: next_state = START;
            START: if (bit_end) next_state = DATA;
            DATA:  if (bit_end && (bit_pos == LAST_DATA_POS)) next_state = STOP;
            STOP:  if (bit_end) next_state = (index == LAST_INDEX) ? IDLE : FETCH;
            default: next_state = IDLE;
        endcase
    end

    // Output decode.  The byte handed to the engine in FETCH is the header,
    // the live register read data, or the accumulated checksum depending on
    // which slot of the frame is being sent.
    always_comb begin
        busy = (state != IDLE);
        load = (state == FETCH) && tx_ready;
        if (index == 4'd0) begin
            load_byte = HEADER;
        end else if (is_reg_index(index)) begin
            load_byte = rd;
        end else begin
            load_byte = checksum;
        end
    end

    // Frame bookkeeping.  ra is pointed at the next register as the previous
    // byte finishes, so it is already stable through the whole FETCH cycle
    // that samples rd.  The checksum folds in each register byte exactly as
    // it is captured, so mid-frame register writes are reflected consistently.
    always_ff @(posedge clk) begin
        if (rst) begin
            index    <= 4'd0;
            ra       <= 3'd0;
            checksum <= 8'h00;
            done     <= 1'b0;
        end else begin
            done <= frame_end;
            if ((state == IDLE) && start) begin
                index    <= 4'd0;
                ra       <= 3'd0;
                checksum <= 8'h00;
            end else if ((state == FETCH) && is_reg_index(index)) begin
                checksum <= checksum ^ rd;
            end else if ((state == STOP) && bit_end && (index != LAST_INDEX)) begin
                index <= index + 4'd1;
                ra    <= index[2:0];
            end
        end
    end

endmodule

// File: tb/tb_reg_dump_tx.sv
// ---------------------------------------------------------------------------
// tb_reg_dump_tx -- self-checking bench for reg_dump_tx with a short bit
// period.  Expected line levels are derived from the frame layout: each byte
// slot is one fetch cycle followed by start, 8 data bits and stop, each held
// for CPB cycles.
// ---------------------------------------------------------------------------
module tb_reg_dump_tx;

    localparam int         CPB          = 4;
    localparam int         BYTE_CYCLES  = 1 + 10 * CPB;
    localparam int         FRAME_BYTES  = 10;
    localparam int         FRAME_CYCLES = FRAME_BYTES * BYTE_CYCLES;
    localparam logic [7:0] HDR          = 8'hA5;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [2:0] ra;
    logic [7:0] rd;
    logic       tx;
    logic       busy;
    logic       done;

    logic [7:0] regs [8];

    int passCount  = 0;
    int failCount  = 0;
    int checkCount = 0;

    always #5 clk = ~clk;

    // Register file model: combinational read from the DUT's address.
    assign rd = regs[ra];

    reg_dump_tx #(
        .CLKS_PER_BIT(CPB),
        .HEADER      (HDR)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .ra   (ra),
        .rd   (rd),
        .tx   (tx),
        .busy (busy),
        .done (done)
    );

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Load the register file (reg0 in the low byte) and optionally raise
    // start for the current cycle.
    task automatic applyStimulus(input logic [63:0] packedRegs, input bit pulseStart);
        for (int i = 0; i < 8; i++) regs[i] = packedRegs[8*i +: 8];
        if (pulseStart) start = 1'b1;
    endtask

    // Idle-line checks over a number of cycles.
    task automatic checkIdle(input string tag, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
            checkOutput({tag, "_tx"}, 32'(tx), 32'd1);
        end
    endtask

    // Walk one frame cycle by cycle from the cycle after start was sampled.
    // The expected byte for each slot is taken from the register file at its
    // fetch cycle; the checksum is the XOR of the register bytes so taken.
    task automatic runFrame(input bit holdStart, input int writeAt, input int writeIdx,
                            input logic [7:0] writeVal, input int pulseA, input int pulseB,
                            input int abortAt);
        logic [7:0] curByte;
        logic [7:0] cks;
        int b;
        int off;
        logic expTx;
        cks = 8'h00;
        curByte = 8'h00;
        for (int n = 0; n < FRAME_CYCLES; n++) begin
            @(negedge clk);
            if (!holdStart) start = (n == pulseA) || (n == pulseB);
            if (n == writeAt) regs[writeIdx] = writeVal;
            b   = n / BYTE_CYCLES;
            off = n % BYTE_CYCLES;
            if (off == 0) begin
                if (b == 0) begin
                    curByte = HDR;
                end else if (b == FRAME_BYTES - 1) begin
                    curByte = cks;
                end else begin
                    curByte = regs[b-1];
                    cks = cks ^ curByte;
                    checkOutput($sformatf("ra_byte%0d", b), 32'(ra), 32'(b - 1));
                end
            end
            if (off == 0)             expTx = 1'b1;
            else if (off <= CPB)      expTx = 1'b0;
            else if (off <= 9 * CPB)  expTx = curByte[(off - CPB - 1) / CPB];
            else                      expTx = 1'b1;
            checkOutput($sformatf("tx_n%0d", n), 32'(tx), 32'(expTx));
            checkOutput($sformatf("busy_n%0d", n), 32'(busy), 32'd1);
            checkOutput($sformatf("done_n%0d", n), 32'(done), 32'd0);
            if (n == abortAt) begin
                rst   = 1'b1;
                start = 1'b0;
                @(negedge clk);
                checkOutput("abort_tx", 32'(tx), 32'd1);
                checkOutput("abort_busy", 32'(busy), 32'd0);
                checkOutput("abort_done", 32'(done), 32'd0);
                checkOutput("abort_ra", 32'(ra), 32'd0);
                rst = 1'b0;
                return;
            end
        end
        @(negedge clk);
        checkOutput("end_done", 32'(done), 32'd1);
        checkOutput("end_busy", 32'(busy), 32'd0);
        checkOutput("end_tx", 32'(tx), 32'd1);
    endtask

    // Directed and randomized scenarios in sequence.
    initial begin
        rst   = 1'b1;
        start = 1'b0;
        for (int i = 0; i < 8; i++) regs[i] = 8'h00;
        repeat (3) @(negedge clk);
        checkOutput("rst_tx", 32'(tx), 32'd1);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_ra", 32'(ra), 32'd0);

        // Reset wins over a simultaneous start.
        start = 1'b1;
        @(negedge clk);
        checkOutput("rstprio_busy", 32'(busy), 32'd0);
        rst   = 1'b0;
        start = 1'b0;
        checkIdle("after_rst", 3);

        // Basic frame with reg0=01: checksum byte is FF.
        $display("[TB] frame reg0=01");
        applyStimulus(64'h80402010_08040201, 1'b1);
        runFrame(1'b0, -1, 0, 8'h00, -1, -1, -1);
        @(negedge clk);
        checkOutput("post1_done", 32'(done), 32'd0);
        checkOutput("post1_busy", 32'(busy), 32'd0);

        // reg0=00 with start re-pulsed mid-frame: ignored, single frame.
        $display("[TB] frame reg0=00 with ignored starts");
        applyStimulus(64'h80402010_08040200, 1'b1);
        runFrame(1'b0, -1, 0, 8'h00, 49, 199, -1);
        checkIdle("noqueue", 5);

        // Register write ahead of its fetch shows up in the frame.
        $display("[TB] frame with mid-frame write");
        applyStimulus(64'h80402010_08040201, 1'b1);
        runFrame(1'b0, 99, 3, 8'h5A, -1, -1, -1);
        checkIdle("post_write", 2);

        // Reset in the middle of a data bit, then a fresh frame.
        $display("[TB] frame aborted by reset");
        applyStimulus(64'h80402010_08040201, 1'b1);
        runFrame(1'b0, -1, 0, 8'h00, -1, -1, 99);
        checkIdle("post_abort", 8);
        applyStimulus(64'h80402010_08040201, 1'b1);
        runFrame(1'b0, -1, 0, 8'h00, -1, -1, -1);
        checkIdle("post_fresh", 2);

        // Randomized register contents, writes and one random abort.
        $display("[TB] randomized frames");
        for (int k = 0; k < 4; k++) begin
            applyStimulus(64'({$urandom(), $urandom()}), 1'b1);
            runFrame(1'b0, int'($urandom_range(0, FRAME_CYCLES - 1)),
                     int'($urandom_range(0, 7)), 8'($urandom()), -1, -1,
                     (k == 3) ? int'($urandom_range(5, 400)) : -1);
            checkIdle("post_rand", 2);
        end

        // Start held high: frames run back to back with one idle cycle.
        $display("[TB] back-to-back frames");
        applyStimulus(64'({$urandom(), $urandom()}), 1'b1);
        runFrame(1'b1, -1, 0, 8'h00, -1, -1, -1);
        runFrame(1'b1, -1, 0, 8'h00, -1, -1, -1);
        start = 1'b0;
        @(negedge clk);
        checkOutput("b2b_end_busy", 32'(busy), 32'd0);
        checkOutput("b2b_end_done", 32'(done), 32'd0);

        $display("[TB] %0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
